// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern detector for a 1-bit data path, one bit per clock. The last N
// enabled bits are kept in a shift history and compared with a run-time
// pattern. A match can only be declared once the history holds N valid bits.
// In non-overlapping mode a match empties the history (fill returns to 0), so
// N fresh bits must arrive before the next match. A saturating counter tallies
// the matches seen since reset.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-high reset, overrides everything
//   en         bit-valid qualifier, in is consumed only when en=1
//   in         serial data bit
//   pattern    target sequence, pattern[N-1] received first, pattern[0] last
//   overlap    1 = matches may share bits, 0 = non-overlapping detection
//   out        registered one-cycle match pulse
//   match_cnt  saturating number of matches since reset
//   hist       shift history, hist[0] is the newest bit
//   fill       number of valid bits in hist, 0..N
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int unsigned N     = 6,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned FW    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in,
    input  logic [N-1:0]     pattern,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [N-1:0]     hist,
    output logic [FW-1:0]    fill
);

    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Candidate values for an enabled edge.
    logic [N-1:0]     hist_n;
    logic [FW-1:0]    fill_n;
    logic             match_c;

    // Next register values.
    logic             out_d;
    logic [CNT_W-1:0] cnt_d;
    logic [N-1:0]     hist_d;
    logic [FW-1:0]    fill_d;

    // History shift: a one-bit history is simply the newest bit.
    generate
        if (N == 1) begin : g_hist_one
            always_comb begin
                hist_n = in;
            end
        end else begin : g_hist_shift
            always_comb begin
                hist_n = {hist[N-2:0], in};
            end
        end
    endgenerate

    // Fill saturates at N; a match requires a full history equal to the pattern.
    always_comb begin
        fill_n  = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
        match_c = (fill_n == FILL_FULL) && (hist_n == pattern);
    end

    // Next-state logic: idle edges hold state and drop the pulse.
    always_comb begin
        out_d  = 1'b0;
        cnt_d  = match_cnt;
        hist_d = hist;
        fill_d = fill;
        if (en) begin
            out_d  = match_c;
            hist_d = hist_n;
            fill_d = (match_c && !overlap) ? '0 : fill_n;
            if (match_c && (match_cnt != CNT_MAX)) begin
                cnt_d = match_cnt + CNT_W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= 1'b0;
            match_cnt <= '0;
            hist      <= '0;
            fill      <= '0;
        end else begin
            out       <= out_d;
            match_cnt <= cnt_d;
            hist      <= hist_d;
            fill      <= fill_d;
        end
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial-pattern detector, successor to the fixed 6-bit one-hot sequence detector.
- Pattern length is set by a parameter; the pattern value is a run-time input.
- Overlapping or non-overlapping detection is selected at run time.
- Adds an input-enable qualifier, a saturating match counter and an observable history/fill state.
- Sits on a 1-bit serial data path, clocked once per data bit.

Parameters:
- N, 6, pattern length in bits (N >= 1).
- CNT_W, 8, width of the match counter.
- FW, $clog2(N+1), width of the fill counter (derived; never overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  bit-valid; `in` is consumed only on edges where en=1.
- in  input  1  serial data bit.
- pattern  input  N  target sequence; pattern[N-1] is the first bit received, pattern[0] the last.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- out  output  1  registered match pulse.
- match_cnt  output  CNT_W  matches detected since reset; saturates.
- hist  output  N  shift history; hist[0] is the newest bit.
- fill  output  FW  valid bits in hist, 0..N.

Behaviour:
- Reset (edge with reset=1), all registers cleared regardless of en:
  - hist=0, fill=0, out=0, match_cnt=0.
  - Reset overrides every simultaneous event; a partial sequence is discarded.
- Edge with en=0:
  - hist, fill and match_cnt hold.
  - out <= 0; out is a single-cycle pulse and never stretches.
- Edge with en=1:
  - hist_n = {hist[N-2:0], in}; for N=1, hist_n = in.
  - fill_n = (fill==N) ? N : fill+1.
  - match = (fill_n==N) && (hist_n==pattern).
  - out <= match.
  - hist <= hist_n.
  - If match and overlap=0: fill <= 0. Otherwise fill <= fill_n.
  - If match and match_cnt != all-ones: match_cnt <= match_cnt+1. If already all-ones: hold.
- Latency: out is high for exactly the one clock cycle following the edge that samples the final pattern bit.
- Overlap:
  - overlap=1: the bits of a match may be reused by the next match.
  - overlap=0: after a match, N fresh enabled bits are required before the next match.
- Control changes:
  - pattern and overlap are sampled on every enabled edge and are not registered.
  - A change to either never clears hist or fill.
  - A change to overlap affects only matches detected after it.
- fill counts only enabled bits; idle (en=0) cycles inside a sequence do not break it.
- No match is possible before N enabled bits have been received since reset or since the last non-overlapping match.

Test Plan:
1. Overlap mode:
   - Stimulus: N=6, pattern=6'b101011, overlap=1, en=1. Stream (first bit first) 0,1,0,1,0,1,1,0,1,0,1,1,0.
   - Required: out high after the edges sampling bit indices 6 and 11, low everywhere else; match_cnt=2.
2. Non-overlap mode:
   - Stimulus: same stream as scenario 1 with overlap=0.
   - Required: out high only after bit 6; fill=0 right after that match; match_cnt=1.
3. Enable gaps:
   - Stimulus: scenario 1 stream with en=0 for 3 cycles inserted between bits 3 and 4 (in toggling randomly during the gap).
   - Required: hist and fill frozen during the gap; out=0 during the gap; matches still occur after bits 6 and 11, each delayed by 3 cycles.
4. Reset mid-operation:
   - Stimulus: send 1,0,1,0,1; assert reset for one edge; then send 1.
   - Required: hist=0 and fill=0 after the reset edge; no match; match_cnt=0; fill=1 after the final bit.
5. Overlap with all-ones pattern:
   - Stimulus: N=6, pattern=6'b111111, 8 consecutive ones with overlap=1, then repeat from reset with overlap=0.
   - Required: overlap=1 gives 3 pulses (after ones 6, 7, 8); overlap=0 gives 1 pulse (after one 6).
6. Counter saturation and N=1:
   - Stimulus: CNT_W=2, N=1, pattern=1, 5 consecutive ones.
   - Required: out high on 5 consecutive cycles; match_cnt goes 1,2,3,3,3 and never wraps.
